// File: rtl/alu_mem_reg_unit.sv
// ALU, 32x16 register-array memory and operand-B buffer for the 16-bit multi-cycle CPU.
// State updates on the falling clock edge; reset clears the buffer and every memory word.
module alu_mem_reg_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a_bus,
  input  logic        lbuff,
  input  logic [2:0]  fsel,
  output logic [15:0] buff,
  output logic [15:0] z_bus,
  output logic        cout,
  input  logic [4:0]  mar,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] mem_din,
  output logic [15:0] mem_dout
);

  logic [15:0] buff_q, buff_d;
  logic [15:0] mem_q [32];
  logic [16:0] sum_w;
  logic [16:0] diff_w;

  assign buff_d = lbuff ? a_bus : buff_q;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      buff_q <= '0;
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else begin
      buff_q <= buff_d;
      if (wr) mem_q[mar] <= mem_din;
    end
  end

  assign buff     = buff_q;
  assign mem_dout = rd ? mem_q[mar] : 16'h0000;

  // 17-bit results: bit 16 is carry for add, borrow for subtract
  assign sum_w  = {1'b0, buff_q} + {1'b0, a_bus};
  assign diff_w = {1'b0, buff_q} - {1'b0, a_bus};

  always_comb begin
    z_bus = 16'h0000;
    cout  = 1'b0;
    unique case (fsel)
      3'b000: z_bus = a_bus;
      3'b001: begin
        z_bus = sum_w[15:0];
        cout  = sum_w[16];
      end
      3'b010: begin
        z_bus = diff_w[15:0];
        cout  = ~diff_w[16];
      end
      3'b011: z_bus = buff_q & a_bus;
      3'b100: z_bus = buff_q | a_bus;
      3'b101: z_bus = ~a_bus;
      3'b110: z_bus = buff_q;
      3'b111: z_bus = 16'h0000;
      default: z_bus = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_alu_mem_reg_unit.sv
// Self-checking bench for alu_mem_reg_unit: ALU vector table plus directed
// buffer, memory and reset sequences.
module tb_alu_mem_reg_unit;

  logic        clk;
  logic        rst;
  logic [15:0] a_bus;
  logic        lbuff;
  logic [2:0]  fsel;
  logic [15:0] buff;
  logic [15:0] z_bus;
  logic        cout;
  logic [4:0]  mar;
  logic        rd;
  logic        wr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;

  int tests;
  int fails;

  typedef struct {
    logic [15:0] b_val;
    logic [15:0] a_val;
    logic [2:0]  fs;
    logic [15:0] z_exp;
    logic        c_exp;
  } vec_t;

  vec_t vecs [15];

  alu_mem_reg_unit dut (
    .clk      (clk),
    .rst      (rst),
    .a_bus    (a_bus),
    .lbuff    (lbuff),
    .fsel     (fsel),
    .buff     (buff),
    .z_bus    (z_bus),
    .cout     (cout),
    .mar      (mar),
    .rd       (rd),
    .wr       (wr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic fall();
    @(negedge clk);
    #1;
  endtask

  task automatic load_buff(input logic [15:0] v);
    a_bus = v;
    lbuff = 1'b1;
    fall();
    lbuff = 1'b0;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst     = 1'b0;
    a_bus   = 16'h0005;
    lbuff   = 1'b0;
    fsel    = 3'b000;
    mar     = 5'd7;
    rd      = 1'b1;
    wr      = 1'b0;
    mem_din = 16'h0000;

    //          buff      a         fsel    z         cout
    vecs[0]  = '{16'hFFFF, 16'h0001, 3'b001, 16'h0000, 1'b1};
    vecs[1]  = '{16'h0005, 16'h0003, 3'b010, 16'h0002, 1'b1};
    vecs[2]  = '{16'h0003, 16'h0005, 3'b010, 16'hFFFE, 1'b0};
    vecs[3]  = '{16'h0F0F, 16'h00FF, 3'b011, 16'h000F, 1'b0};
    vecs[4]  = '{16'h0F0F, 16'h00FF, 3'b100, 16'h0FFF, 1'b0};
    vecs[5]  = '{16'h0F0F, 16'h00FF, 3'b101, 16'hFF00, 1'b0};
    vecs[6]  = '{16'h0F0F, 16'h00FF, 3'b110, 16'h0F0F, 1'b0};
    vecs[7]  = '{16'h0F0F, 16'h00FF, 3'b111, 16'h0000, 1'b0};
    vecs[8]  = '{16'h0F0F, 16'h00FF, 3'b000, 16'h00FF, 1'b0};
    vecs[9]  = '{16'h8000, 16'h8000, 3'b001, 16'h0000, 1'b1};
    vecs[10] = '{16'h1234, 16'h1234, 3'b010, 16'h0000, 1'b1};
    vecs[11] = '{16'h0001, 16'h0001, 3'b001, 16'h0002, 1'b0};
    vecs[12] = '{16'h0000, 16'h0001, 3'b010, 16'hFFFF, 1'b0};
    vecs[13] = '{16'hFFFF, 16'hFFFF, 3'b001, 16'hFFFE, 1'b1};
    vecs[14] = '{16'hA5A5, 16'h5A5A, 3'b100, 16'hFFFF, 1'b0};

    // Reset values
    #2;
    rst = 1'b1;
    #3;
    check16("reset_buff", buff, 16'h0000);
    check16("reset_mem_dout", mem_dout, 16'h0000);
    check16("reset_z", z_bus, 16'h0005);
    check1 ("reset_cout", cout, 1'b0);
    fall();
    rst = 1'b0;
    fall();

    // Buffer load and hold
    load_buff(16'h1234);
    check16("buff_load", buff, 16'h1234);
    a_bus = 16'hFFFF;
    lbuff = 1'b0;
    fall();
    check16("buff_hold", buff, 16'h1234);

    // ALU vector table
    for (int i = 0; i < 15; i++) begin
      load_buff(vecs[i].b_val);
      a_bus = vecs[i].a_val;
      fsel  = vecs[i].fs;
      #1;
      check16($sformatf("alu_z[%0d]", i), z_bus, vecs[i].z_exp);
      check1 ($sformatf("alu_cout[%0d]", i), cout, vecs[i].c_exp);
    end

    // Memory write and read
    rd      = 1'b0;
    mar     = 5'd21;
    mem_din = 16'hBEEF;
    wr      = 1'b1;
    fall();
    wr = 1'b0;
    rd = 1'b1;
    #1;
    check16("mem_read21", mem_dout, 16'hBEEF);
    rd = 1'b0;
    #1;
    check16("mem_rd_off", mem_dout, 16'h0000);
    rd  = 1'b1;
    mar = 5'd20;
    #1;
    check16("mem_read20", mem_dout, 16'h0000);
    mar     = 5'd21;
    mem_din = 16'h1111;
    wr      = 1'b1;
    #1;
    check16("mem_rdwr_before", mem_dout, 16'hBEEF);
    fall();
    check16("mem_rdwr_after", mem_dout, 16'h1111);
    wr = 1'b0;

    // Address boundaries
    mar     = 5'd31;
    mem_din = 16'hC0DE;
    wr      = 1'b1;
    fall();
    mar     = 5'd0;
    mem_din = 16'h0BAD;
    fall();
    wr  = 1'b0;
    mar = 5'd31;
    #1;
    check16("mem_read31", mem_dout, 16'hC0DE);
    mar = 5'd0;
    #1;
    check16("mem_read0", mem_dout, 16'h0BAD);

    // Reset mid-operation
    load_buff(16'h1234);
    mar     = 5'd21;
    mem_din = 16'hBEEF;
    wr      = 1'b1;
    fall();
    wr = 1'b0;
    #1;
    check16("pre_rst_mem21", mem_dout, 16'hBEEF);
    check16("pre_rst_buff", buff, 16'h1234);
    #2;
    wr      = 1'b1;
    lbuff   = 1'b1;
    a_bus   = 16'h5555;
    mem_din = 16'h7777;
    fsel    = 3'b110;
    rst     = 1'b1;
    #1;
    check16("midrst_buff", buff, 16'h0000);
    check16("midrst_mem21", mem_dout, 16'h0000);
    check16("midrst_z", z_bus, 16'h0000);
    fall();
    check16("rst_edge_buff", buff, 16'h0000);
    check16("rst_edge_mem21", mem_dout, 16'h0000);
    mar = 5'd31;
    #1;
    check16("rst_edge_mem31", mem_dout, 16'h0000);

    // First edge after reset release loads and writes normally
    #2;
    rst     = 1'b0;
    a_bus   = 16'hABCD;
    mem_din = 16'h4242;
    mar     = 5'd21;
    #1;
    check16("post_rst_before", mem_dout, 16'h0000);
    fall();
    lbuff = 1'b0;
    wr    = 1'b0;
    check16("post_rst_buff", buff, 16'hABCD);
    check16("post_rst_mem21", mem_dout, 16'h4242);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
